// File: rtl/reg_file_gen.sv
// Register file with two combinational read ports (write-through bypass), one
// write port, and a clear engine that zeroes one entry per cycle while busy.
module reg_file_gen #(
    parameter int  WIDTH    = 16,
    parameter int  DEPTH    = 8,
    parameter int  ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    input  logic             clr_req,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    output logic             wr_ack,
    output logic             busy,
    output logic             dbg_state_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] regs_q [DEPTH];

    logic             zero_hit;
    logic             clr_we;
    logic             user_we;
    logic             byp_a, byp_b;

    // Clear engine state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_ptr_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // clr_req is only sampled in IDLE, so requests during a clear are ignored.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_ptr_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Write handshake: wr is a request held by the source for one cycle; wr_ack
    // in that same cycle means the data lands at the next edge, otherwise the
    // request is dropped (no retry is implied).
    always_comb begin
        zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
        wr_ack   = wr && !busy_q && !zero_hit;
        clr_we   = (state_q == ST_CLEAR);
        user_we  = wr_ack && !reset;
        byp_a    = user_we && (rd_addr_a == wr_addr);
        byp_b    = user_we && (rd_addr_b == wr_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (clr_we) begin
            regs_q[clr_ptr_q] <= '0;
        end else if (wr_ack) begin
            regs_q[wr_addr] <= d_in;
        end
    end

    // Clear-engine writes never reach the bypass path; reads see stored data.
    always_comb begin
        d_out_a = byp_a ? d_in : regs_q[rd_addr_a];
        d_out_b = byp_b ? d_in : regs_q[rd_addr_b];
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) d_out_a = '0;
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) d_out_b = '0;
    end

    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_file_gen.sv
// Bench for reg_file_gen: default, ZERO_REG=1 and 32x16 instances on one clock.
module tb_reg_file_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        wr, clr_req, wr_ack, busy, dbg;
    logic [2:0]  wr_addr, rd_a, rd_b;
    logic [15:0] d_in, d_out_a, d_out_b;

    logic        z_wr, z_clr_req, z_wr_ack, z_busy, z_dbg;
    logic [2:0]  z_wr_addr, z_rd_a, z_rd_b;
    logic [15:0] z_d_in, z_d_out_a, z_d_out_b;

    logic        w_wr, w_clr_req, w_wr_ack, w_busy, w_dbg;
    logic [3:0]  w_wr_addr, w_rd_a, w_rd_b;
    logic [31:0] w_d_in, w_d_out_a, w_d_out_b;

    reg_file_gen u_dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .d_in(d_in),
        .rd_addr_a(rd_a), .rd_addr_b(rd_b), .clr_req(clr_req),
        .d_out_a(d_out_a), .d_out_b(d_out_b), .wr_ack(wr_ack), .busy(busy),
        .dbg_state_o(dbg)
    );

    reg_file_gen #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) u_dut_z (
        .clk(clk), .reset(reset), .wr(z_wr), .wr_addr(z_wr_addr), .d_in(z_d_in),
        .rd_addr_a(z_rd_a), .rd_addr_b(z_rd_b), .clr_req(z_clr_req),
        .d_out_a(z_d_out_a), .d_out_b(z_d_out_b), .wr_ack(z_wr_ack), .busy(z_busy),
        .dbg_state_o(z_dbg)
    );

    reg_file_gen #(.WIDTH(32), .DEPTH(16), .ZERO_REG(0)) u_dut_w (
        .clk(clk), .reset(reset), .wr(w_wr), .wr_addr(w_wr_addr), .d_in(w_d_in),
        .rd_addr_a(w_rd_a), .rd_addr_b(w_rd_b), .clr_req(w_clr_req),
        .d_out_a(w_d_out_a), .d_out_b(w_d_out_b), .wr_ack(w_wr_ack), .busy(w_busy),
        .dbg_state_o(w_dbg)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] expv;
    logic [15:0] mem_m [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_all(input logic [15:0] seed);
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; wr_addr = 3'(i); d_in = seed + 16'(i * 16'h1111);
            @(posedge clk); #1;
            mem_m[i] = d_in;
        end
        wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr = 0; wr_addr = 0; d_in = 0; rd_a = 0; rd_b = 0; clr_req = 0;
        z_wr = 0; z_wr_addr = 0; z_d_in = 0; z_rd_a = 0; z_rd_b = 0; z_clr_req = 0;
        w_wr = 0; w_wr_addr = 0; w_d_in = 0; w_rd_a = 0; w_rd_b = 0; w_clr_req = 0;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (dbg !== 1'b0) begin bad++; $display("FAIL reset_state: got %b expected 0", dbg); end
        wr = 1'b1; wr_addr = 3'd4; d_in = 16'h7777; #1;
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL reset_wr_ack: got %b expected 1", wr_ack); end
        @(posedge clk); #1;
        wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_a = 3'(i); exp_q.push_back(32'h0); #1;
            expv = exp_q.pop_front();
            total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL reset_read[%0d]: got %h expected %h", i, d_out_a, expv[15:0]); end
        end
        for (int i = 0; i < 8; i++) mem_m[i] = 16'h0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_defaults();
        wr = 1'b1; wr_addr = 3'd3; d_in = 16'hA5A5; rd_a = 3'd0; rd_b = 3'd1;
        @(negedge clk);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL default_wr_ack: got %b expected 1", wr_ack); end
        @(posedge clk); #1;
        mem_m[3] = 16'hA5A5;
        wr = 1'b0; rd_a = 3'd3; rd_b = 3'd2;
        exp_q.push_back(32'hA5A5); exp_q.push_back(32'h0000);
        @(negedge clk);
        expv = exp_q.pop_front();
        total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL default_read_a: got %h expected %h", d_out_a, expv[15:0]); end
        expv = exp_q.pop_front();
        total++; if (d_out_b !== expv[15:0]) begin bad++; $display("FAIL default_read_b: got %h expected %h", d_out_b, expv[15:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        wr = 1'b1; wr_addr = 3'd5; d_in = 16'h1234; rd_a = 3'd5; rd_b = 3'd5;
        exp_q.push_back(32'h1234); exp_q.push_back(32'h1234);
        @(negedge clk);
        expv = exp_q.pop_front();
        total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL bypass_both_a: got %h expected %h", d_out_a, expv[15:0]); end
        expv = exp_q.pop_front();
        total++; if (d_out_b !== expv[15:0]) begin bad++; $display("FAIL bypass_both_b: got %h expected %h", d_out_b, expv[15:0]); end
        @(posedge clk); #1;
        mem_m[5] = 16'h1234;
        wr_addr = 3'd6; d_in = 16'hBEEF; rd_a = 3'd6; rd_b = 3'd5;
        exp_q.push_back(32'hBEEF); exp_q.push_back(32'h1234);
        @(negedge clk);
        expv = exp_q.pop_front();
        total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL bypass_one_a: got %h expected %h", d_out_a, expv[15:0]); end
        expv = exp_q.pop_front();
        total++; if (d_out_b !== expv[15:0]) begin bad++; $display("FAIL bypass_one_b: got %h expected %h", d_out_b, expv[15:0]); end
        @(posedge clk); #1;
        mem_m[6] = 16'hBEEF;
        wr = 1'b0;
    endtask

    task automatic test_random_rw();
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1)); wr_addr = 3'($urandom_range(0, 7));
            d_in = 16'($urandom); rd_a = 3'($urandom_range(0, 7)); rd_b = 3'($urandom_range(0, 7));
            exp_q.push_back(32'((wr && rd_a == wr_addr) ? d_in : mem_m[rd_a]));
            exp_q.push_back(32'((wr && rd_b == wr_addr) ? d_in : mem_m[rd_b]));
            @(negedge clk);
            total++; if (wr_ack !== wr) begin bad++; $display("FAIL rand_wr_ack[%0d]: got %b expected %b", n, wr_ack, wr); end
            expv = exp_q.pop_front();
            total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL rand_read_a[%0d]: got %h expected %h", n, d_out_a, expv[15:0]); end
            expv = exp_q.pop_front();
            total++; if (d_out_b !== expv[15:0]) begin bad++; $display("FAIL rand_read_b[%0d]: got %h expected %h", n, d_out_b, expv[15:0]); end
            @(posedge clk); #1;
            if (wr) mem_m[wr_addr] = d_in;
        end
        wr = 1'b0;
    endtask

    task automatic test_clear();
        int  cnt;
        bit  done;
        fill_all(16'h0101);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        cnt = 0; done = 0;
        while (!done && cnt < 20) begin
            wr = 1'b1; wr_addr = 3'($urandom_range(0, 7)); d_in = 16'($urandom);
            clr_req = (cnt >= 2 && cnt <= 5);
            rd_a = 3'((cnt == 0) ? 0 : cnt - 1); rd_b = 3'(cnt);
            exp_q.push_back(32'((cnt == 0) ? mem_m[0] : 16'h0));
            exp_q.push_back(32'((cnt < 8) ? mem_m[cnt] : 16'h0));
            @(negedge clk);
            if (busy === 1'b1) begin
                total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL clear_wr_ack[%0d]: got %b expected 0", cnt, wr_ack); end
                total++; if (dbg !== 1'b1) begin bad++; $display("FAIL clear_state[%0d]: got %b expected 1", cnt, dbg); end
                expv = exp_q.pop_front();
                total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL clear_read_a[%0d]: got %h expected %h", cnt, d_out_a, expv[15:0]); end
                expv = exp_q.pop_front();
                total++; if (d_out_b !== expv[15:0]) begin bad++; $display("FAIL clear_read_b[%0d]: got %h expected %h", cnt, d_out_b, expv[15:0]); end
                cnt++;
                @(posedge clk); #1;
            end else begin
                exp_q.delete();
                done = 1;
            end
        end
        wr = 1'b0; clr_req = 1'b0;
        total++; if (cnt != 8) begin bad++; $display("FAIL clear_busy_cycles: got %0d expected 8", cnt); end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) mem_m[i] = 16'h0;
        for (int i = 0; i < 8; i++) begin
            rd_a = 3'(i); rd_b = 3'(7 - i);
            exp_q.push_back(32'(mem_m[i])); exp_q.push_back(32'(mem_m[7 - i]));
            @(negedge clk);
            expv = exp_q.pop_front();
            total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL after_clear_a[%0d]: got %h expected %h", i, d_out_a, expv[15:0]); end
            expv = exp_q.pop_front();
            total++; if (d_out_b !== expv[15:0]) begin bad++; $display("FAIL after_clear_b[%0d]: got %h expected %h", i, d_out_b, expv[15:0]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wr_and_clr();
        int cnt;
        wr = 1'b1; wr_addr = 3'd2; d_in = 16'h5A5A; clr_req = 1'b1; rd_a = 3'd0;
        @(negedge clk);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wrclr_wr_ack: got %b expected 1", wr_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrclr_busy_pre: got %b expected 0", busy); end
        @(posedge clk); #1;
        wr = 1'b0; clr_req = 1'b0; rd_a = 3'd2;
        exp_q.push_back(32'h5A5A);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrclr_busy_start: got %b expected 1", busy); end
        expv = exp_q.pop_front();
        total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL wrclr_written: got %h expected %h", d_out_a, expv[15:0]); end
        cnt = 1;
        while (cnt < 20) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) break;
            cnt++;
        end
        total++; if (cnt != 8) begin bad++; $display("FAIL wrclr_busy_cycles: got %0d expected 8", cnt); end
        mem_m[2] = 16'h0;
        exp_q.push_back(32'(mem_m[2]));
        @(negedge clk);
        expv = exp_q.pop_front();
        total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL wrclr_cleared: got %h expected %h", d_out_a, expv[15:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        fill_all(16'h2222);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        #1 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_now: got %b expected 0", busy); end
        total++; if (dbg !== 1'b0) begin bad++; $display("FAIL midrst_state: got %b expected 0", dbg); end
        for (int i = 0; i < 8; i++) mem_m[i] = 16'h0;
        for (int i = 0; i < 8; i++) begin
            rd_a = 3'(i); exp_q.push_back(32'(mem_m[i])); #1;
            expv = exp_q.pop_front();
            total++; if (d_out_a !== expv[15:0]) begin bad++; $display("FAIL midrst_read[%0d]: got %h expected %h", i, d_out_a, expv[15:0]); end
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        wr = 1'b1; wr_addr = 3'd6; d_in = 16'hC0DE; rd_a = 3'd6;
        @(negedge clk);
        total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL midrst_wr_ack: got %b expected 1", wr_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
        @(posedge clk); #1;
        mem_m[6] = 16'hC0DE;
        wr = 1'b0; rd_b = 3'd6; exp_q.push_back(32'(mem_m[6]));
        @(negedge clk);
        expv = exp_q.pop_front();
        total++; if (d_out_b !== expv[15:0]) begin bad++; $display("FAIL midrst_readback: got %h expected %h", d_out_b, expv[15:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_reg();
        z_wr = 1'b1; z_wr_addr = 3'd0; z_d_in = 16'hFFFF; z_rd_a = 3'd0; z_rd_b = 3'd0;
        @(negedge clk);
        total++; if (z_wr_ack !== 1'b0) begin bad++; $display("FAIL zero_wr_ack: got %b expected 0", z_wr_ack); end
        total++; if (z_d_out_a !== 16'h0) begin bad++; $display("FAIL zero_read_same_cycle: got %h expected 0000", z_d_out_a); end
        total++; if (z_d_out_b !== 16'h0) begin bad++; $display("FAIL zero_read_b_same_cycle: got %h expected 0000", z_d_out_b); end
        @(posedge clk); #1;
        z_wr_addr = 3'd1; z_d_in = 16'h0BAD; z_rd_b = 3'd1;
        @(negedge clk);
        total++; if (z_d_out_a !== 16'h0) begin bad++; $display("FAIL zero_read_after: got %h expected 0000", z_d_out_a); end
        total++; if (z_wr_ack !== 1'b1) begin bad++; $display("FAIL zero_wr1_ack: got %b expected 1", z_wr_ack); end
        total++; if (z_d_out_b !== 16'h0BAD) begin bad++; $display("FAIL zero_bypass1: got %h expected 0bad", z_d_out_b); end
        @(posedge clk); #1;
        z_wr = 1'b0; z_rd_a = 3'd1; z_rd_b = 3'd0;
        @(negedge clk);
        total++; if (z_d_out_a !== 16'h0BAD) begin bad++; $display("FAIL zero_read1: got %h expected 0bad", z_d_out_a); end
        total++; if (z_busy !== 1'b0 || z_dbg !== 1'b0) begin bad++; $display("FAIL zero_idle: got busy=%b state=%b expected 0 0", z_busy, z_dbg); end
        @(posedge clk); #1;
    endtask

    task automatic test_wide();
        int cnt;
        w_wr = 1'b1; w_wr_addr = 4'd15; w_d_in = 32'hDEADBEEF; w_rd_a = 4'd0;
        @(negedge clk);
        total++; if (w_wr_ack !== 1'b1) begin bad++; $display("FAIL wide_wr_ack: got %b expected 1", w_wr_ack); end
        @(posedge clk); #1;
        w_wr = 1'b0; w_rd_a = 4'd15; w_rd_b = 4'd0;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
        @(negedge clk);
        expv = exp_q.pop_front();
        total++; if (w_d_out_a !== expv) begin bad++; $display("FAIL wide_read_a: got %h expected %h", w_d_out_a, expv); end
        expv = exp_q.pop_front();
        total++; if (w_d_out_b !== expv) begin bad++; $display("FAIL wide_read_b: got %h expected %h", w_d_out_b, expv); end
        @(posedge clk); #1;
        w_clr_req = 1'b1;
        @(posedge clk); #1;
        w_clr_req = 1'b0;
        total++; if (w_dbg !== 1'b1) begin bad++; $display("FAIL wide_clear_state: got %b expected 1", w_dbg); end
        cnt = 0;
        while (w_busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        total++; if (cnt != 16) begin bad++; $display("FAIL wide_busy_cycles: got %0d expected 16", cnt); end
        exp_q.push_back(32'h0);
        @(negedge clk);
        expv = exp_q.pop_front();
        total++; if (w_d_out_a !== expv) begin bad++; $display("FAIL wide_cleared: got %h expected %h", w_d_out_a, expv); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_bypass();
        test_random_rw();
        test_clear();
        test_wr_and_clr();
        test_mid_reset();
        test_zero_reg();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_gen.md
REG_FILE_GEN -- requirements
Module: reg_file_gen

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register (SHALL be >= 1).
REQ-002 Parameter DEPTH, default 8, register count (SHALL be a power of 2, >= 2).
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 SHALL be hard-wired to zero.
REQ-004 Derived constant AW = log2(DEPTH) SHALL size all address ports.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wr  in  1  write request.
REQ-008 wr_addr  in  AW  write address.
REQ-009 d_in  in  WIDTH  write data.
REQ-010 rd_addr_a  in  AW  read address, port A.
REQ-011 rd_addr_b  in  AW  read address, port B.
REQ-012 clr_req  in  1  request for a sequential clear of all registers.
REQ-013 d_out_a  out  WIDTH  read data, port A.
REQ-014 d_out_b  out  WIDTH  read data, port B.
REQ-015 wr_ack  out  1  combinational; high when the current-cycle write is accepted.
REQ-016 busy  out  1  registered; high while the clear engine runs.

Function
REQ-017 Storage SHALL be DEPTH registers of WIDTH bits each.
REQ-018 Reads SHALL be combinational: d_out_x = reg[rd_addr_x], with zero read latency.
REQ-019 Write acceptance: wr_ack = wr & ~busy & ~(ZERO_REG & wr_addr==0).
REQ-020 An accepted write SHALL store d_in into reg[wr_addr] at the next rising edge.
REQ-021 Bypass: when wr_ack=1 and rd_addr_x==wr_addr in the same cycle, d_out_x SHALL equal d_in (new data).
REQ-022 Bypass SHALL apply to ports A and B independently and simultaneously.
REQ-023 With ZERO_REG=1, reads of address 0 SHALL return 0.
REQ-024 With ZERO_REG=1, writes to address 0 SHALL be dropped with wr_ack=0 and SHALL NOT bypass.
REQ-025 Clear engine states: IDLE and CLEAR; an AW-bit pointer clr_ptr.
REQ-026 IDLE with clr_req=1: next state SHALL be CLEAR, clr_ptr <= 0, busy <= 1.
REQ-027 In CLEAR, each cycle SHALL write 0 to reg[clr_ptr] and increment clr_ptr by 1.
REQ-028 In CLEAR with clr_ptr==DEPTH-1: after that final write, the next state SHALL be IDLE, busy <= 0, clr_ptr <= 0.
REQ-029 A clear SHALL take exactly DEPTH cycles with busy high.
REQ-030 clr_req while in CLEAR SHALL be ignored; it does not restart or extend the clear.
REQ-031 If wr and clr_req are both asserted in IDLE, the write SHALL be accepted in that cycle and the clear SHALL start the following cycle.
REQ-032 While busy=1, wr SHALL be dropped (wr_ack=0, no storage change, no bypass).
REQ-033 Reads during CLEAR SHALL return current contents: 0 for already-cleared entries, old data for the rest.
REQ-034 Clear-engine writes SHALL NOT be bypassed to the read ports.

Reset
REQ-035 reset=1 SHALL immediately, independent of clk, set all registers to 0, state to IDLE, clr_ptr to 0 and busy to 0.
REQ-036 reset asserted mid-clear SHALL abort the clear; after release the block SHALL be in IDLE with all registers 0.
REQ-037 While reset=1, wr_ack SHALL still follow REQ-019, but no write SHALL take effect.

Verification
REQ-038 Defaults: write 0xA5A5 to addr 3, next cycle read A=3 -> d_out_a=0xA5A5; B=2 -> d_out_b=0x0000.
REQ-039 Bypass: with wr=1, wr_addr=5, d_in=0x1234, rd_addr_a=rd_addr_b=5 in the same cycle -> both outputs 0x1234 that cycle.
REQ-040 Clear: fill all 8 registers with nonzero data, pulse clr_req -> busy high exactly 8 cycles; wr during that window gives wr_ack=0; all registers read 0 after.
REQ-041 Mid-clear reset: assert reset asynchronously in clear cycle 3 -> busy=0 at once; all reads 0; a write after release is accepted.
REQ-042 ZERO_REG=1: write 0xFFFF to addr 0 -> wr_ack=0, read addr 0 returns 0x0000 (also during the write cycle).
REQ-043 Parametric: WIDTH=32, DEPTH=16 -> write/read addr 15 with 0xDEADBEEF round-trips; clear takes 16 cycles.
